// File: rtl/layer_output_serializer.sv
// Layer output serializer: captures a full layer of neuron outputs when every
// neuron reports valid in the same cycle, replays the words one per cycle for
// the next layer, and tracks the signed maximum word and its index (argmax).
module layer_output_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [numNeurons*dataWidth-1:0]   layer_out,
  input  logic [numNeurons-1:0]             layer_valid,
  output logic [dataWidth-1:0]              data_out,
  output logic                              data_out_valid,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(numNeurons)-1:0]     max_index,
  output logic                              overflow,
  output logic                              sync_err
);

  localparam int IDX_W = $clog2(numNeurons);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeurons - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(0);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                            state_r, state_s;
  logic [IDX_W-1:0]                  cnt_r, cnt_s;
  logic [numNeurons*dataWidth-1:0]   hold_r, hold_s;
  logic [dataWidth-1:0]              data_out_r, data_out_s;
  logic                              valid_r, valid_s;
  logic                              done_r, done_s;
  logic [dataWidth-1:0]              max_r, max_s;
  logic [IDX_W-1:0]                  idx_r, idx_s;
  logic [IDX_W-1:0]                  max_index_r, max_index_s;
  logic                              overflow_r, overflow_s;
  logic                              sync_err_r, sync_err_s;

  logic                              all_valid_s;
  logic                              partial_s;
  logic [dataWidth-1:0]              word_s;

  assign all_valid_s = &layer_valid;
  assign partial_s   = (|layer_valid) & ~all_valid_s;
  assign word_s      = hold_r[int'(cnt_r)*dataWidth +: dataWidth];

  assign data_out       = data_out_r;
  assign data_out_valid = valid_r;
  assign busy           = (state_r != IDLE);
  assign frame_done     = done_r;
  assign max_index      = max_index_r;
  assign overflow       = overflow_r;
  assign sync_err       = sync_err_r;

  // Next-state and next-value logic for the capture / shift / done sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    hold_s      = hold_r;
    data_out_s  = data_out_r;
    valid_s     = 1'b0;
    done_s      = 1'b0;
    max_s       = max_r;
    idx_s       = idx_r;
    max_index_s = max_index_r;
    overflow_s  = overflow_r;
    sync_err_s  = sync_err_r | partial_s;

    case (state_r)
      IDLE: begin
        if (all_valid_s) begin
          hold_s  = layer_out;
          cnt_s   = ZERO_IDX;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        data_out_s = word_s;
        valid_s    = 1'b1;
        // Strict greater-than so ties keep the lower index.
        if (cnt_r == ZERO_IDX) begin
          max_s = word_s;
          idx_s = ZERO_IDX;
        end else if ($signed(word_s) > $signed(max_r)) begin
          max_s = word_s;
          idx_s = cnt_r;
        end else begin
          max_s = max_r;
          idx_s = idx_r;
        end
        cnt_s = cnt_r + ONE_IDX;
        if (cnt_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
        // A frame arriving while streaming is dropped, not captured.
        if (all_valid_s) begin
          overflow_s = 1'b1;
        end else begin
          overflow_s = overflow_r;
        end
      end

      DONE: begin
        valid_s     = 1'b0;
        done_s      = 1'b1;
        max_index_s = idx_r;
        state_s     = IDLE;
        if (all_valid_s) begin
          overflow_s = 1'b1;
        end else begin
          overflow_s = overflow_r;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_IDX;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO_IDX;
      hold_r      <= '0;
      data_out_r  <= '0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
      max_r       <= '0;
      idx_r       <= ZERO_IDX;
      max_index_r <= ZERO_IDX;
      overflow_r  <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      hold_r      <= hold_s;
      data_out_r  <= data_out_s;
      valid_r     <= valid_s;
      done_r      <= done_s;
      max_r       <= max_s;
      idx_r       <= idx_s;
      max_index_r <= max_index_s;
      overflow_r  <= overflow_s;
      sync_err_r  <= sync_err_s;
    end
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed testbench for layer_output_serializer with numNeurons=4, dataWidth=16.
module tb_layer_output_serializer;

  logic        clk;
  logic        rst;
  logic [63:0] layer_out;
  logic [3:0]  layer_valid;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic        frame_done;
  logic [1:0]  max_index;
  logic        overflow;
  logic        sync_err;

  int checks;
  int failures;

  layer_output_serializer #(.numNeurons(4), .dataWidth(16)) dut (
    .clk(clk), .rst(rst), .layer_out(layer_out), .layer_valid(layer_valid),
    .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
    .frame_done(frame_done), .max_index(max_index), .overflow(overflow),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 0 with the frame already driven; returns in the frame_done cycle.
  task automatic expect_frame(input logic [63:0] w, input logic [1:0] idx, input logic [1:0] prev_idx,
                              input int inject_cycle, input logic [63:0] inj, input bit scramble,
                              input string tag);
    tick();
    layer_valid = 4'h0;
    if (scramble) layer_out = {$urandom, $urandom};
    checks++;
    if (data_out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_cycle1: valid=%b busy=%b expected valid=0 busy=1", tag, data_out_valid, busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      layer_valid = 4'h0;
      if (scramble) layer_out = {$urandom, $urandom};
      if (inject_cycle == k + 2) begin
        layer_out   = inj;
        layer_valid = 4'hF;
      end
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== w[k*16 +: 16]) begin
        failures++;
        $display("FAIL %s_word%0d: valid=%b data=%h expected valid=1 data=%h",
                 tag, k, data_out_valid, data_out, w[k*16 +: 16]);
      end
      checks++;
      if (frame_done !== 1'b0 || max_index !== prev_idx || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_stream%0d: done=%b idx=%0d busy=%b expected done=0 idx=%0d busy=1",
                 tag, k, frame_done, max_index, busy, prev_idx);
      end
    end
    tick();
    layer_valid = 4'h0;
    checks++;
    if (frame_done !== 1'b1 || data_out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: done=%b valid=%b busy=%b expected done=1 valid=0 busy=0",
               tag, frame_done, data_out_valid, busy);
    end
    checks++;
    if (max_index !== idx) begin
      failures++;
      $display("FAIL %s_max_index: got %0d expected %0d", tag, max_index, idx);
    end
  endtask

  // Reset values of every output.
  task automatic test_reset();
    rst = 1'b1;
    layer_valid = 4'h0;
    layer_out = 64'h0;
    tick();
    tick();
    checks++;
    if (data_out !== 16'h0 || data_out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: data=%h valid=%b busy=%b done=%b expected all 0",
               data_out, data_out_valid, busy, frame_done);
    end
    checks++;
    if (max_index !== 2'd0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: idx=%0d ovf=%b sync=%b expected all 0", max_index, overflow, sync_err);
    end
    rst = 1'b0;
    tick();
  endtask

  // Basic frame, positive words, max in the middle.
  task automatic test_basic();
    layer_out   = {16'h0050, 16'h0200, 16'h7F00, 16'h0100};
    layer_valid = 4'hF;
    expect_frame({16'h0050, 16'h0200, 16'h7F00, 16'h0100}, 2'd1, 2'd0, 0, 64'h0, 1'b0, "basic");
  endtask

  // All-negative words: signed compare with a tie at index 2.
  task automatic test_negative();
    layer_out   = {16'h8000, 16'hFF00, 16'hFE00, 16'hFF00};
    layer_valid = 4'hF;
    expect_frame({16'h8000, 16'hFF00, 16'hFE00, 16'hFF00}, 2'd0, 2'd1, 0, 64'h0, 1'b0, "negative");
  endtask

  // Positive tie keeps the lower index.
  task automatic test_ties();
    layer_out   = {16'h0001, 16'h0020, 16'h0020, 16'h0010};
    layer_valid = 4'hF;
    expect_frame({16'h0001, 16'h0020, 16'h0020, 16'h0010}, 2'd1, 2'd0, 0, 64'h0, 1'b0, "ties");
  endtask

  // Frame during busy is dropped; frame in the frame_done cycle is accepted back-to-back.
  task automatic test_back_to_back();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_pre: got %b expected 0", overflow);
    end
    layer_out   = {16'h0006, 16'h0003, 16'h0004, 16'h0005};
    layer_valid = 4'hF;
    expect_frame({16'h0006, 16'h0003, 16'h0004, 16'h0005}, 2'd3, 2'd1, 3,
                 {16'h4444, 16'h7FFF, 16'h2222, 16'h1111}, 1'b0, "ovf_first");
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got %b expected 1", overflow);
    end
    layer_out   = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h8000};
    layer_valid = 4'hF;
    expect_frame({16'hFFFE, 16'hFFFF, 16'h0000, 16'h8000}, 2'd1, 2'd3, 0, 64'h0, 1'b0, "b2b_second");
    tick();
    checks++;
    if (data_out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: valid=%b busy=%b done=%b expected 0 0 0", data_out_valid, busy, frame_done);
    end
  endtask

  // Partial layer_valid flags sync_err and captures nothing.
  task automatic test_sync_err();
    layer_out   = 64'h1234_5678_9ABC_DEF0;
    layer_valid = 4'b0111;
    tick();
    layer_valid = 4'h0;
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_err_set: got %b expected 1", sync_err);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sync_err_idle%0d: busy=%b valid=%b expected 0 0", i, busy, data_out_valid);
      end
      tick();
    end
  endtask

  // Reset in the word-2 cycle abandons the frame; a new frame then streams.
  task automatic test_reset_midframe();
    layer_out   = {16'h0050, 16'h0200, 16'h7F00, 16'h0100};
    layer_valid = 4'hF;
    tick();
    layer_valid = 4'h0;
    tick();
    tick();
    tick();
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 16'h0200) begin
      failures++;
      $display("FAIL rst_mid_word2: valid=%b data=%h expected 1 0200", data_out_valid, data_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || frame_done !== 1'b0
        || sync_err !== 1'b0 || max_index !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_after: valid=%b busy=%b ovf=%b done=%b sync=%b idx=%0d expected all 0",
               data_out_valid, busy, overflow, frame_done, sync_err, max_index);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (frame_done !== 1'b0 || data_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_quiet%0d: done=%b valid=%b expected 0 0", i, frame_done, data_out_valid);
      end
    end
    layer_out   = {16'h0001, 16'h0020, 16'h0020, 16'h0010};
    layer_valid = 4'hF;
    expect_frame({16'h0001, 16'h0020, 16'h0020, 16'h0010}, 2'd1, 2'd0, 0, 64'h0, 1'b0, "rst_mid_new");
  endtask

  // layer_out changes every cycle during SHIFT; the stream uses the captured words.
  task automatic test_scramble();
    layer_out   = {16'h8000, 16'hFF00, 16'hFE00, 16'hFF00};
    layer_valid = 4'hF;
    expect_frame({16'h8000, 16'hFF00, 16'hFE00, 16'hFF00}, 2'd0, 2'd1, 0, 64'h0, 1'b1, "scramble");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    layer_valid = 4'h0;
    layer_out   = 64'h0;
    test_reset();
    test_basic();
    test_negative();
    test_ties();
    test_back_to_back();
    test_sync_err();
    test_reset_midframe();
    test_scramble();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
